// File: rtl/step_sequencer.sv
// Tempo-driven step sequencer: turns edges of the tempo square wave into note-on/off
// events read from a programmable step memory, buffered in a 2-entry event FIFO.
module step_sequencer #(
    parameter int unsigned STEPS  = 16,
    parameter int unsigned NOTE_W = 7,
    localparam int unsigned AW    = $clog2(STEPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tempo_clk,
    input  logic              run,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [NOTE_W-1:0] wr_note,
    input  logic              wr_gate,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic              ev_on,
    output logic [NOTE_W-1:0] ev_note,
    output logic [AW-1:0]     next_step,
    output logic              overrun
);

    typedef enum logic {StIdle, StPlay} state_e;

    state_e state_q, state_d;

    logic              tempo_q;
    logic              rise, fall;
    logic [STEPS-1:0]  mem_gate_q;
    logic [NOTE_W-1:0] mem_note_q [STEPS];
    logic [AW-1:0]     step_q, step_d;
    logic              sounding_q, sounding_d;
    logic [NOTE_W-1:0] snd_note_q, snd_note_d;

    logic              push, push_on;
    logic [NOTE_W-1:0] push_note;

    logic [1:0]        fifo_on_q;
    logic [NOTE_W-1:0] fifo_note_q [2];
    logic              rd_ptr_q, wr_ptr_q;
    logic [1:0]        count_q;
    logic              overrun_q;
    logic              full, pop, push_ok;

    assign rise = tempo_clk & ~tempo_q;
    assign fall = ~tempo_clk & tempo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (run)  state_d = StPlay;
            StPlay: if (!run) state_d = StIdle;
        endcase
    end

    // Dropping run outranks any same-cycle edge; edges in the IDLE->PLAY cycle are ignored.
    always_comb begin
        push       = 1'b0;
        push_on    = 1'b0;
        push_note  = snd_note_q;
        step_d     = step_q;
        sounding_d = sounding_q;
        snd_note_d = snd_note_q;
        if (state_q == StPlay) begin
            if (!run) begin
                push       = sounding_q;
                sounding_d = 1'b0;
                step_d     = '0;
            end else if (rise) begin
                if (mem_gate_q[step_q]) begin
                    push       = 1'b1;
                    push_on    = 1'b1;
                    push_note  = mem_note_q[step_q];
                    sounding_d = 1'b1;
                    snd_note_d = mem_note_q[step_q];
                end
                step_d = step_q + AW'(1);
            end else if (fall) begin
                push       = sounding_q;
                sounding_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tempo_q    <= 1'b0;
            step_q     <= '0;
            sounding_q <= 1'b0;
            snd_note_q <= '0;
            mem_gate_q <= '0;
            for (int i = 0; i < int'(STEPS); i++) begin
                mem_note_q[i] <= '0;
            end
        end else begin
            tempo_q    <= tempo_clk;
            step_q     <= step_d;
            sounding_q <= sounding_d;
            snd_note_q <= snd_note_d;
            if (wr_en) begin
                mem_gate_q[wr_addr] <= wr_gate;
                mem_note_q[wr_addr] <= wr_note;
            end
        end
    end

    assign full    = (count_q == 2'd2);
    assign pop     = ev_valid & ev_ready;
    assign push_ok = push & (~full | pop);

    // When full with a pop, the write lands in the slot the head is vacating.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_on_q      <= '0;
            fifo_note_q[0] <= '0;
            fifo_note_q[1] <= '0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            count_q        <= '0;
            overrun_q      <= 1'b0;
        end else begin
            if (push_ok) begin
                fifo_on_q[wr_ptr_q]   <= push_on;
                fifo_note_q[wr_ptr_q] <= push_note;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
            if (push && !push_ok) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign ev_valid  = (count_q != 2'd0);
    assign ev_on     = fifo_on_q[rd_ptr_q];
    assign ev_note   = fifo_note_q[rd_ptr_q];
    assign next_step = step_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed scenarios plus a randomized phase, all checked each
// cycle against an event-queue reference model of the sequencer.
module tb_step_sequencer;

    localparam int unsigned STEPS  = 16;
    localparam int unsigned NOTE_W = 7;
    localparam int unsigned AW     = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tempo_clk = 1'b0;
    logic              run = 1'b0;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [NOTE_W-1:0] wr_note = '0;
    logic              wr_gate = 1'b0;
    logic              ev_valid;
    logic              ev_ready = 1'b1;
    logic              ev_on;
    logic [NOTE_W-1:0] ev_note;
    logic [AW-1:0]     next_step;
    logic              overrun;

    step_sequencer #(.STEPS(STEPS), .NOTE_W(NOTE_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .tempo_clk (tempo_clk),
        .run       (run),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_note   (wr_note),
        .wr_gate   (wr_gate),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_on     (ev_on),
        .ev_note   (ev_note),
        .next_step (next_step),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Tempo generator: toggles tempo_clk every thalf cycles while enabled.
    bit tempo_on = 0;
    int thalf = 8;
    int tcnt = 0;

    // Reference model: events are {on, note} bytes in a queue of at most two.
    bit         m_play, m_snd, m_tprev, m_ovr;
    int         m_step, m_sn;
    bit         m_gate [STEPS];
    int         m_note [STEPS];
    logic [7:0] m_q[$];

    task automatic compare(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit         r_edge, f_edge, pop, push;
        logic [7:0] ev;
        if (rst) begin
            m_play = 0; m_snd = 0; m_tprev = 0; m_ovr = 0; m_step = 0; m_sn = 0;
            for (int i = 0; i < STEPS; i++) begin
                m_gate[i] = 0;
                m_note[i] = 0;
            end
            m_q.delete();
            return;
        end
        r_edge = tempo_clk && !m_tprev;
        f_edge = !tempo_clk && m_tprev;
        pop    = (m_q.size() != 0) && ev_ready;
        push   = 0;
        ev     = '0;
        if (!m_play) begin
            if (run) m_play = 1;
        end else if (!run) begin
            if (m_snd) begin
                push = 1;
                ev   = {1'b0, 7'(m_sn)};
            end
            m_snd = 0; m_step = 0; m_play = 0;
        end else if (r_edge) begin
            if (m_gate[m_step]) begin
                push  = 1;
                ev    = {1'b1, 7'(m_note[m_step])};
                m_snd = 1;
                m_sn  = m_note[m_step];
            end
            m_step = (m_step + 1) % STEPS;
        end else if (f_edge) begin
            if (m_snd) begin
                push = 1;
                ev   = {1'b0, 7'(m_sn)};
            end
            m_snd = 0;
        end
        if (wr_en) begin
            m_gate[wr_addr] = wr_gate;
            m_note[wr_addr] = int'(wr_note);
        end
        m_tprev = tempo_clk;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < 2) m_q.push_back(ev);
            else m_ovr = 1;
        end
    endtask

    task automatic check_outputs();
        logic exp_v;
        exp_v = (m_q.size() != 0);
        compare("ev_valid", 16'(ev_valid), 16'(exp_v));
        if (exp_v) begin
            compare("ev_on", 16'(ev_on), 16'(m_q[0][7]));
            compare("ev_note", 16'(ev_note), 16'(m_q[0][6:0]));
        end
        compare("next_step", 16'(next_step), 16'(m_step));
        compare("overrun", 16'(overrun), 16'(m_ovr));
    endtask

    task automatic tick();
        if (tempo_on) begin
            tcnt++;
            if (tcnt >= thalf) begin
                tcnt      = 0;
                tempo_clk = ~tempo_clk;
            end
        end
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input int a, input int n, input bit g);
        wr_en   = 1;
        wr_addr = AW'(a);
        wr_note = NOTE_W'(n);
        wr_gate = g;
        tick();
        wr_en = 0;
    endtask

    task automatic restart_tempo();
        tempo_on  = 0;
        tempo_clk = 0;
        tcnt      = 0;
        thalf     = 8;
    endtask

    initial begin
        // Reset state
        rst = 1;
        ticks(2);
        rst = 0;
        tick();
        compare("rst_ev_valid", 16'(ev_valid), 16'd0);
        compare("rst_ev_on", 16'(ev_on), 16'd0);
        compare("rst_ev_note", 16'(ev_note), 16'd0);
        compare("rst_next_step", 16'(next_step), 16'd0);
        compare("rst_overrun", 16'(overrun), 16'd0);

        // Three-step pattern with a rest
        wr(0, 60, 1);
        wr(1, 0, 0);
        wr(2, 64, 1);
        restart_tempo();
        run = 1;
        tempo_on = 1;
        ticks(3 * 16 + 4);
        compare("pat_next_step", 16'(next_step), 16'd3);
        run = 0;
        ticks(2);

        // All 16 steps gated, 17 rises to wrap
        for (int i = 0; i < STEPS; i++) wr(i, i, 1);
        restart_tempo();
        run = 1;
        tempo_on = 1;
        ticks(17 * 16 + 4);
        compare("wrap_next_step", 16'(next_step), 16'd1);
        run = 0;
        ticks(2);

        // Downstream stall across rise, fall and a dropped rise
        restart_tempo();
        run = 1;
        tempo_on = 1;
        ticks(5);
        ev_ready = 0;
        ticks(18);
        compare("stall_no_ovr", 16'(overrun), 16'd0);
        ticks(2);
        compare("stall_ovr", 16'(overrun), 16'd1);
        ev_ready = 1;
        ticks(6);
        run = 0;
        ticks(2);

        // Drop run mid-note, then resume from step 0
        rst = 1;
        tick();
        rst = 0;
        wr(0, 60, 1);
        wr(1, 62, 1);
        restart_tempo();
        run = 1;
        tempo_on = 1;
        ticks(10);
        run = 0;
        tick();
        compare("drop_next_step", 16'(next_step), 16'd0);
        ticks(2);
        run = 1;
        ticks(20);
        run = 0;
        ticks(2);

        // Rewrite the sounding step before its fall
        restart_tempo();
        run = 1;
        tempo_on = 1;
        ticks(10);
        wr(0, 70, 1);
        ticks(16 * 16 + 10);
        run = 0;
        ticks(2);

        // Reset mid-note with events pending
        restart_tempo();
        run = 1;
        tempo_on = 1;
        ticks(7);
        ev_ready = 0;
        ticks(10);
        rst = 1;
        tick();
        rst = 0;
        tick();
        compare("rst2_ev_valid", 16'(ev_valid), 16'd0);
        compare("rst2_overrun", 16'(overrun), 16'd0);
        ev_ready = 1;
        ticks(60);

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            ev_ready = ($urandom_range(3) != 0);
            if ($urandom_range(63) == 0) run = ~run;
            if ($urandom_range(31) == 0) thalf = int'($urandom_range(5, 1));
            rst = ($urandom_range(499) == 0);
            if ($urandom_range(7) == 0) begin
                wr_en   = 1;
                wr_addr = AW'($urandom_range(STEPS - 1));
                wr_note = NOTE_W'($urandom);
                wr_gate = ($urandom_range(3) != 0);
            end else begin
                wr_en = 0;
            end
            tick();
        end
        rst   = 0;
        wr_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
